imem_responder: RTL and testbench

- Instruction-memory responder: the memory side of the core's fetch interface. The core presents a PC; this block returns the instruction word.
- Word-addressed array based at BASE, with configurable access latency and valid/ready handshakes on both request and response.
- A side load port lets the bench or boot logic fill the memory.
- One request outstanding at a time; back-to-back issue is supported when the response is consumed.

---
 rtl/imem_responder_if.sv | 31 +++
 rtl/imem_responder.sv | 105 ++++++++++
 tb/tb_imem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch-side bus between the core (master) and the instruction memory responder (slave).
// Request and response each use their own valid/ready handshake.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_inst;
    logic        resp_err;

    modport master (
        output req_valid,
        output req_addr,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_inst,
        input  resp_err
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_inst,
        output resp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word-addressed array at BASE with fixed access latency,
// one outstanding fetch, and a side load port for filling the memory.
module imem_responder #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE       = 32'h80000000,
    parameter int          LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_responder_if.slave       bus,
    input  logic                  ld_en,
    input  logic [DEPTH_LOG2-1:0] ld_addr,
    input  logic [31:0]           ld_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        capture;
    logic        accept;
    logic [31:0] addr_q;
    logic [31:0] cap_addr;
    logic [31:0] off;
    logic        err;
    logic [31:0] resp_inst_q;
    logic        resp_err_q;
    logic        unused_off_bits;

    logic [31:0] mem [2**DEPTH_LOG2];

    assign bus.req_ready  = (state == IDLE) || ((state == RESP) && bus.resp_ready);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_inst  = resp_inst_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state != IDLE);

    // With single-cycle latency the capture edge is the accept edge, so the live address is used.
    assign cap_addr        = (LATENCY == 1) ? bus.req_addr : addr_q;
    assign off             = cap_addr - BASE;
    assign err             = (cap_addr[1:0] != 2'b00) || (off[31:DEPTH_LOG2+2] != '0);
    assign unused_off_bits = ^off[1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: state_next = IDLE;
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = RESP;
                    cnt_next   = 4'd0;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: if (bus.resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // An accept (from IDLE, or on the RESP handshake edge) starts the next fetch.
        if (accept) begin
            if (LATENCY == 1) begin
                state_next = RESP;
                capture    = 1'b1;
            end else begin
                state_next = WAIT;
                cnt_next   = 4'(LATENCY - 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= 32'd0;
            resp_inst_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) addr_q <= bus.req_addr;
            if (capture) begin
                resp_err_q  <= err;
                resp_inst_q <= err ? 32'd0 : mem[off[DEPTH_LOG2+1:2]];
            end
        end
    end

    // Memory has no reset so boot contents survive a core reset; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: fetch timing, backpressure, back-to-back issue,
// address errors, reset mid-fetch and load/capture collision.
module tb_imem_responder;

    localparam int          DEPTH_LOG2 = 10;
    localparam logic [31:0] BASE       = 32'h80000000;
    localparam int          LATENCY    = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ld_en = 1'b0;
    logic [9:0]      ld_addr = '0;
    logic [31:0]     ld_data = '0;
    logic            busy;
    int              vectors = 0;
    int              miscompares = 0;

    imem_responder_if bus ();

    imem_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .BASE       (BASE),
        .LATENCY    (LATENCY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Issue one fetch with resp_ready high and check latency, data and the return to IDLE.
    task automatic apply_stimulus(input string tag, input logic [31:0] addr,
                                  input logic [31:0] exp_inst, input logic exp_err);
        int cycles;
        cycles = 0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.resp_ready = 1'b1;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = 32'h0;
            end
        end while (!bus.resp_valid && cycles < 20);
        check_output({tag, " latency"}, 32'(cycles), 32'(LATENCY));
        check_output({tag, " inst"}, bus.resp_inst, exp_inst);
        check_output({tag, " err"}, 32'(bus.resp_err), 32'(exp_err));
        @(negedge clk);
        check_output({tag, " done valid"}, 32'(bus.resp_valid), 32'd0);
        check_output({tag, " done busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'h0;
        bus.resp_ready = 1'b0;

        load_word(10'd0, 32'h00000297);
        load_word(10'd1, 32'h00028823);
        load_word(10'd1023, 32'hCAFEF00D);
        check_output("reset valid", 32'(bus.resp_valid), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset inst", bus.resp_inst, 32'd0);
        check_output("reset err", 32'(bus.resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("post reset ready", 32'(bus.req_ready), 32'd1);

        // Basic fetch, then stall in RESP with the next request already presented.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h80000000;
        @(negedge clk);
        check_output("t1 wait busy", 32'(busy), 32'd1);
        check_output("t1 wait valid", 32'(bus.resp_valid), 32'd0);
        check_output("t1 wait ready", 32'(bus.req_ready), 32'd0);
        bus.req_addr = 32'h80000004;
        @(negedge clk);
        check_output("t1 valid", 32'(bus.resp_valid), 32'd1);
        check_output("t1 inst", bus.resp_inst, 32'h00000297);
        check_output("t1 err", 32'(bus.resp_err), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check_output("t2 stall valid", 32'(bus.resp_valid), 32'd1);
            check_output("t2 stall inst", bus.resp_inst, 32'h00000297);
            check_output("t2 stall ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        #1;
        check_output("t3 comb ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output("t3 b2b wait valid", 32'(bus.resp_valid), 32'd0);
        check_output("t3 b2b wait busy", 32'(busy), 32'd1);
        @(negedge clk);
        check_output("t3 second valid", 32'(bus.resp_valid), 32'd1);
        check_output("t3 second inst", bus.resp_inst, 32'h00028823);
        @(negedge clk);
        check_output("t3 idle valid", 32'(bus.resp_valid), 32'd0);
        check_output("t3 idle inst hold", bus.resp_inst, 32'h00028823);
        check_output("t3 idle busy", 32'(busy), 32'd0);

        apply_stimulus("t4 misaligned", 32'h80000002, 32'h0, 1'b1);
        apply_stimulus("t4 below base", 32'h7FFFFFFC, 32'h0, 1'b1);
        apply_stimulus("t4 past end", 32'h80001000, 32'h0, 1'b1);
        apply_stimulus("t4 last word", 32'h80000FFC, 32'hCAFEF00D, 1'b0);

        // Reset while a response is pending in RESP.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h80000004;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_output("t5 resp before reset", 32'(bus.resp_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_output("t5 resp async drop", 32'(bus.resp_valid), 32'd0);
        check_output("t5 resp async inst", bus.resp_inst, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bus.resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_output("t5 no stale resp", 32'(bus.resp_valid), 32'd0);
        end

        // Reset while the fetch is still counting down in WAIT.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h80000000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check_output("t5 wait busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_output("t5 wait drop valid", 32'(bus.resp_valid), 32'd0);
        check_output("t5 wait drop busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("t5 release ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        check_output("t5 no resp after", 32'(bus.resp_valid), 32'd0);
        apply_stimulus("t5 refetch", 32'h80000000, 32'h00000297, 1'b0);

        // Overwrite word 0 on the very edge that captures it.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h80000000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        ld_en   = 1'b1;
        ld_addr = 10'd0;
        ld_data = 32'hDEADBEEF;
        @(negedge clk);
        ld_en = 1'b0;
        check_output("t6 collide valid", 32'(bus.resp_valid), 32'd1);
        check_output("t6 collide old data", bus.resp_inst, 32'h00000297);
        @(negedge clk);
        apply_stimulus("t6 new data", 32'h80000000, 32'hDEADBEEF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
